// File: rtl/out_bcd_display.sv
// out_bcd_display: converts a binary value to packed BCD with a sequential
// double-dabble engine, then multiplexes the digits onto a 7-segment display
// with leading-zero blanking. The display scan runs independently of the converter.
module out_bcd_display #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 16
) (
   input  logic                  mclk,
   input  logic                  rst,
   input  logic                  mclk_en,
   input  logic [WIDTH-1:0]      i_data,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_valid,
   output logic [DIGITS-1:0]     o_an,
   output logic [6:0]            o_seg
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {S_IDLE, S_CONVERT} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_start;
   logic               w_last_iter;

   logic               r_force;
   logic [WIDTH-1:0]   r_last;
   logic [WIDTH-1:0]   r_shift;
   logic [BCD_W-1:0]   r_scratch;
   logic [CNT_W-1:0]   r_count;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_valid;
   logic [DIV_W-1:0]   r_div;
   logic [IDX_W-1:0]   r_idx;

   logic [BCD_W-1:0]   w_adj;
   logic [BCD_W-1:0]   w_scratch_nxt;
   logic [3:0]         w_nib;
   logic [IDX_W-1:0]   w_msd;

   // Add 3 to every nibble that is 5 or more, ahead of the shift.
   function automatic logic [BCD_W-1:0] f_dabble_adj(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Segment pattern for one BCD digit; codes above 9 go dark.
   function automatic logic [6:0] f_seg(input logic [3:0] n);
      case (n)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   assign w_adj         = f_dabble_adj(r_scratch);
   assign w_scratch_nxt = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};

   // Converter state register
   always_ff @(posedge mclk or posedge rst) begin
      if (rst)          r_state <= S_IDLE;
      else if (mclk_en) r_state <= w_state_nxt;
   end

   // Converter next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_start)     w_state_nxt = S_CONVERT;
         S_CONVERT: if (w_last_iter) w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   // Converter control outputs: start on a new value (or forced), finish on the last iteration
   always_comb begin
      w_start     = (r_state == S_IDLE) && ((i_data != r_last) || r_force);
      w_last_iter = (r_state == S_CONVERT) && (r_count == CNT_W'(WIDTH - 1));
   end

   // Converter datapath: capture, iterate, publish the finished result
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_force   <= 1'b1;
         r_last    <= '0;
         r_shift   <= '0;
         r_scratch <= '0;
         r_count   <= '0;
         r_bcd     <= '0;
         r_valid   <= 1'b0;
      end else if (mclk_en) begin
         if (w_start) begin
            r_shift   <= i_data;
            r_last    <= i_data;
            r_scratch <= '0;
            r_count   <= '0;
            r_force   <= 1'b0;
         end else if (r_state == S_CONVERT) begin
            r_scratch <= w_scratch_nxt;
            r_shift   <= r_shift << 1;
            r_count   <= r_count + CNT_W'(1);
            if (w_last_iter) begin
               r_bcd   <= w_scratch_nxt;
               r_valid <= 1'b1;
            end
         end
      end
   end

   // Scan divider and digit index, free-running on enabled edges
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (mclk_en) begin
         if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   // Digit select, selected nibble and most-significant nonzero digit position
   always_comb begin
      o_an  = '0;
      w_nib = 4'd0;
      w_msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            o_an[i] = 1'b1;
            w_nib   = r_bcd[4*i +: 4];
         end
         if (r_bcd[4*i +: 4] != 4'd0) w_msd = IDX_W'(i);
      end
   end

   // Segment drive: dark until a result exists and above the leading digit
   always_comb begin
      if (!r_valid || (r_idx > w_msd)) o_seg = 7'h00;
      else                             o_seg = f_seg(w_nib);
   end

   assign o_bcd   = r_bcd;
   assign o_valid = r_valid;

endmodule

// File: doc/out_bcd_display.md
OUT_BCD_DISPLAY -- requirements
Module: out_bcd_display

Interface
REQ-001 Parameter WIDTH, default 8: width of the binary value from the output register.
REQ-002 Parameter DIGITS, default 3: number of BCD digits and display positions. It SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 Parameter SCAN_DIV, default 16, minimum 1: enabled cycles per displayed digit.
REQ-004 mclk  input  1: the single clock; all state SHALL change on its rising edge, except on reset.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 mclk_en  input  1: clock enable. All sequential state SHALL hold when it is 0.
REQ-007 i_data  input  WIDTH: binary value, driven by the output register's o_data.
REQ-008 o_bcd  output  4*DIGITS: packed BCD result. Digit 0 (ones) SHALL sit in bits [3:0].
REQ-009 o_valid  output  1: high once o_bcd holds a completed conversion.
REQ-010 o_an  output  DIGITS: one-hot, active-high digit select.
REQ-011 o_seg  output  7: active-high segments, with bit0=a through bit6=g.

Function
REQ-012 Converter FSM SHALL have exactly two states: IDLE and CONVERT.
REQ-013 IDLE to CONVERT SHALL occur on an enabled edge when i_data differs from last_data or the force flag is set. That edge (E0) SHALL:
- capture i_data into shift and last_data;
- clear the BCD scratch and the iteration count;
- clear force.
REQ-014 CONVERT SHALL perform one double-dabble iteration per enabled edge:
- add 3 to every scratch nibble >= 5;
- then shift {scratch, shift} left by 1.
REQ-015 On the WIDTH-th iteration edge (E_WIDTH), the block SHALL:
- load o_bcd with the final scratch;
- set o_valid=1;
- return to IDLE.
REQ-016 Latency from E0 to an updated o_bcd SHALL be exactly WIDTH enabled edges. o_bcd SHALL hold its old value until E_WIDTH.
REQ-017 i_data changes during CONVERT SHALL be ignored. The first enabled IDLE edge afterwards SHALL start a new conversion if i_data != last_data.
REQ-018 With i_data stable, no further conversion SHALL start, and o_bcd/o_valid SHALL hold indefinitely.
REQ-019 Scan counter: a divider counting 0..SCAN_DIV-1 SHALL advance on enabled edges. On wrap it SHALL advance digit index 0..DIGITS-1, and index DIGITS-1 SHALL wrap to 0.
REQ-020 Scan SHALL run independently of the converter FSM, including during CONVERT.
REQ-021 o_an SHALL equal 1 << index.
REQ-022 o_seg SHALL be the decode of o_bcd nibble[index]: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex). Nibbles above 9 SHALL decode to 00.
REQ-023 Leading-zero blanking: o_seg SHALL be 00 for any index above the most-significant nonzero digit. Index 0 SHALL never be blanked.
REQ-024 When o_valid=0, o_seg SHALL be 00 for all indices.
REQ-025 o_an and o_seg SHALL be combinational from registered state only, with no path from i_data.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, set:
- state=IDLE, force=1, o_valid=0, o_bcd=0;
- last_data=0, scratch/shift/count=0;
- divider=0, index=0, o_an=1, o_seg=00.
REQ-027 Reset asserted mid-CONVERT SHALL abort the conversion with no partial o_bcd update.
REQ-028 After release, the first enabled edge SHALL start a conversion because force=1, regardless of i_data.

Verification
REQ-029 Reset, i_data=0, mclk_en=1 -> o_valid=0 through E7; at E8 o_valid=1, o_bcd=000, o_seg=3F when o_an=001 and 00 otherwise.
REQ-030 i_data 0->255 -> o_bcd=255 exactly 8 enabled edges after capture; scan shows o_an=001/010/100 with o_seg=6D/6D/5B.
REQ-031 mclk_en high every other clock with i_data=128 -> all state frozen on disabled clocks; o_bcd=128 at the 8th enabled edge after capture (16 clocks).
REQ-032 i_data 100, then 42 two enabled edges into the conversion -> o_bcd=100 first, then a second conversion gives o_bcd=042; digit 2 blanked, digit 1 shows 66.
REQ-033 rst pulsed between clock edges at iteration 5 -> o_valid=0, o_bcd=000, o_an=001 before the next edge; a fresh conversion runs after release.
REQ-034 SCAN_DIV=2, DIGITS=3, mclk_en=1 -> o_an sequence 001,001,010,010,100,100,001 across consecutive edges.
